// File: rtl/core_n_pkg.sv
// Shared definitions for the core_n slice: opcode encodings, FSM state enum,
// flag bit positions and small decode helpers.
package core_n_pkg;

   localparam int unsigned INST_W = 16;
   localparam int unsigned REG_AW = 4;
   localparam int unsigned FLAG_W = 4;

   // Status register layout {C,Z,V,N}
   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_ADC  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_EOR  = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_ANDI = 4'h8;
   localparam logic [3:0] OP_LDI  = 4'h9;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_e;

   // Opcodes that write rd
   function automatic logic op_writes(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_LDI);
   endfunction

   // Opcodes whose inst[7:4] is a source register (not part of K)
   function automatic logic op_uses_rr(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_MOV);
   endfunction

endpackage

// File: rtl/core_n_alu.sv
// Combinational ALU for core_n: result and next flag value per opcode.
// Ports: op (opcode), a (R[rd]), b (R[rr]), k (zero-extended immediate),
//        flags_in (current {C,Z,V,N}), res_c (result), flags_c (next flags).
module core_n_alu
   import core_n_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [3:0]        op,
   input  logic [DW-1:0]     a,
   input  logic [DW-1:0]     b,
   input  logic [DW-1:0]     k,
   input  logic [FLAG_W-1:0] flags_in,
   output logic [DW-1:0]     res_c,
   output logic [FLAG_W-1:0] flags_c
);

   localparam int unsigned SW = DW + 1;

   logic [SW-1:0] sum;
   logic          upd_arith;
   logic          upd_logic;

   always_comb begin
      sum       = '0;
      res_c     = '0;
      flags_c   = flags_in;
      upd_arith = 1'b0;
      upd_logic = 1'b0;

      case (op)
         OP_ADD:  begin sum = {1'b0, a} + {1'b0, b}; upd_arith = 1'b1; end
         OP_ADC:  begin sum = {1'b0, a} + {1'b0, b} + SW'(flags_in[FLAG_C]); upd_arith = 1'b1; end
         // Bit DW of the extended difference is the borrow (a < b unsigned)
         OP_SUB:  begin sum = {1'b0, a} - {1'b0, b}; upd_arith = 1'b1; end
         OP_AND:  begin res_c = a & b; upd_logic = 1'b1; end
         OP_OR:   begin res_c = a | b; upd_logic = 1'b1; end
         OP_EOR:  begin res_c = a ^ b; upd_logic = 1'b1; end
         OP_ANDI: begin res_c = a & k; upd_logic = 1'b1; end
         OP_MOV:  res_c = b;
         OP_LDI:  res_c = k;
         default: ;
      endcase

      if (upd_arith) begin
         res_c           = sum[DW-1:0];
         flags_c[FLAG_C] = sum[DW];
         // Overflow: operand signs (b inverted for SUB) agree but result sign differs
         if (op == OP_SUB)
            flags_c[FLAG_V] = (a[DW-1] != b[DW-1]) && (res_c[DW-1] != a[DW-1]);
         else
            flags_c[FLAG_V] = (a[DW-1] == b[DW-1]) && (res_c[DW-1] != a[DW-1]);
      end

      if (upd_logic)
         flags_c[FLAG_V] = 1'b0;

      if (upd_arith || upd_logic) begin
         flags_c[FLAG_Z] = (res_c == '0);
         flags_c[FLAG_N] = res_c[DW-1];
      end
   end

endmodule

// File: rtl/core_n.sv
// core_n: two-cycle (FETCH/EXEC) register-machine core with NREG registers.
// Ports: clk, rst (sync, active-high); inst/inst_valid/inst_ready instruction
//        handshake; wb_valid/wb_addr/wb_data writeback taking effect at the next
//        edge; flags {C,Z,V,N}; illegal (sticky); dbg_addr/dbg_data register peek.
module core_n
   import core_n_pkg::*;
#(
   parameter int unsigned DW   = 8,
   parameter int unsigned NREG = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       inst,
   input  logic              inst_valid,
   output logic              inst_ready,
   output logic              wb_valid,
   output logic [3:0]        wb_addr,
   output logic [DW-1:0]     wb_data,
   output logic [3:0]        flags,
   output logic              illegal,
   input  logic [3:0]        dbg_addr,
   output logic [DW-1:0]     dbg_data
);

   state_e              state_q, state_d;
   logic [INST_W-1:0]   ir_q, ir_d;
   logic [DW-1:0]       regs_q [NREG];
   logic [DW-1:0]       regs_d [NREG];
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic                illegal_q, illegal_d;

   logic [3:0]          op;
   logic [REG_AW-1:0]   rd;
   logic [REG_AW-1:0]   rr;
   logic [DW-1:0]       k_val;
   logic [DW-1:0]       rd_val;
   logic [DW-1:0]       rr_val;
   logic                ill;
   logic                in_exec;
   logic [DW-1:0]       alu_res;
   logic [FLAG_W-1:0]   alu_flags;

   assign op    = ir_q[15:12];
   assign rd    = ir_q[11:8];
   assign rr    = ir_q[7:4];
   assign k_val = DW'(ir_q[7:0]);

   assign in_exec = (state_q == ST_EXEC);

   // rr is only a register index for reg-reg ops; for ANDI/LDI those bits are K
   assign ill = (op > OP_LDI)
             || (op_writes(op)  && (32'(rd) >= NREG))
             || (op_uses_rr(op) && (32'(rr) >= NREG));

   // Register reads by comparison so out-of-range indices read as zero
   always_comb begin
      rd_val   = '0;
      rr_val   = '0;
      dbg_data = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (rd == REG_AW'(i))       rd_val   = regs_q[i];
         if (rr == REG_AW'(i))       rr_val   = regs_q[i];
         if (dbg_addr == REG_AW'(i)) dbg_data = regs_q[i];
      end
   end

   core_n_alu #(.DW(DW)) u_alu (
      .op       (op),
      .a        (rd_val),
      .b        (rr_val),
      .k        (k_val),
      .flags_in (flags_q),
      .res_c    (alu_res),
      .flags_c  (alu_flags)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FETCH;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: if (inst_valid) state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_FETCH;
         default:  state_d = ST_FETCH;
      endcase
   end

   // FSM outputs; rst masks wb_valid since the write will not happen
   always_comb begin
      inst_ready = 1'b0;
      wb_valid   = 1'b0;
      wb_addr    = '0;
      wb_data    = '0;
      case (state_q)
         ST_FETCH: inst_ready = 1'b1;
         ST_EXEC: begin
            wb_valid = op_writes(op) && !ill && !rst;
            wb_addr  = rd;
            wb_data  = alu_res;
         end
         default: ;
      endcase
   end

   // Datapath next state: IR capture, register writeback, flags, sticky illegal
   always_comb begin
      ir_d      = ir_q;
      regs_d    = regs_q;
      flags_d   = flags_q;
      illegal_d = illegal_q;

      if (inst_ready && inst_valid)
         ir_d = inst;

      if (wb_valid) begin
         for (int unsigned i = 0; i < NREG; i++)
            if (rd == REG_AW'(i)) regs_d[i] = alu_res;
      end

      if (in_exec) begin
         if (ill) illegal_d = 1'b1;
         else     flags_d   = alu_flags;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q      <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign flags   = flags_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_core_n.sv
// Directed bench for core_n: one default instance (NREG=16) and one with NREG=4.
module tb_core_n;

   logic        clk;
   logic        rst;

   logic [15:0] inst0, inst1;
   logic        inst_valid0, inst_valid1;
   logic        inst_ready0, inst_ready1;
   logic        wb_valid0, wb_valid1;
   logic [3:0]  wb_addr0, wb_addr1;
   logic [7:0]  wb_data0, wb_data1;
   logic [3:0]  flags0, flags1;
   logic        illegal0, illegal1;
   logic [3:0]  dbg_addr0, dbg_addr1;
   logic [7:0]  dbg_data0, dbg_data1;

   int checks = 0;
   int errors = 0;

   core_n #(.DW(8), .NREG(16)) u_dut (
      .clk(clk), .rst(rst), .inst(inst0), .inst_valid(inst_valid0),
      .inst_ready(inst_ready0), .wb_valid(wb_valid0), .wb_addr(wb_addr0),
      .wb_data(wb_data0), .flags(flags0), .illegal(illegal0),
      .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
   );

   core_n #(.DW(8), .NREG(4)) u_dut4 (
      .clk(clk), .rst(rst), .inst(inst1), .inst_valid(inst_valid1),
      .inst_ready(inst_ready1), .wb_valid(wb_valid1), .wb_addr(wb_addr1),
      .wb_data(wb_data1), .flags(flags1), .illegal(illegal1),
      .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one instruction from a negedge in FETCH; returns at the negedge back in FETCH.
   task automatic run(input bit sel, input string tag, input logic [15:0] i,
                      input logic exp_v, input logic [3:0] exp_a,
                      input logic [7:0] exp_d, input logic [3:0] exp_f);
      check_eq({tag, "_ready"}, sel ? inst_ready1 : inst_ready0, 1);
      if (sel) begin inst1 = i; inst_valid1 = 1'b1; end
      else     begin inst0 = i; inst_valid0 = 1'b1; end
      @(negedge clk);
      inst_valid0 = 1'b0; inst_valid1 = 1'b0;
      check_eq({tag, "_busy"}, sel ? inst_ready1 : inst_ready0, 0);
      check_eq({tag, "_wbv"},  sel ? wb_valid1 : wb_valid0, 32'(exp_v));
      if (exp_v) begin
         check_eq({tag, "_wba"}, sel ? wb_addr1 : wb_addr0, 32'(exp_a));
         check_eq({tag, "_wbd"}, sel ? wb_data1 : wb_data0, 32'(exp_d));
      end
      @(negedge clk);
      check_eq({tag, "_flags"}, sel ? flags1 : flags0, 32'(exp_f));
   endtask

   task automatic peek0(input string tag, input logic [3:0] a, input logic [7:0] exp);
      dbg_addr0 = a;
      #1;
      check_eq(tag, dbg_data0, 32'(exp));
   endtask

   initial begin
      rst = 1'b1;
      inst0 = '0; inst1 = '0; inst_valid0 = 1'b0; inst_valid1 = 1'b0;
      dbg_addr0 = '0; dbg_addr1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check_eq("rst_ready", inst_ready0, 1);
      check_eq("rst_flags", flags0, 0);
      check_eq("rst_illegal", illegal0, 0);
      check_eq("rst_wbv", wb_valid0, 0);
      peek0("rst_r1", 4'd1, 8'h00);

      // LDI / ADD carry+zero / ADC
      run(0, "ldi_r1", 16'h915A, 1, 4'd1, 8'h5A, 4'b0000);
      peek0("r1_5a", 4'd1, 8'h5A);
      run(0, "ldi_r2", 16'h92A6, 1, 4'd2, 8'hA6, 4'b0000);
      run(0, "add",    16'h1120, 1, 4'd1, 8'h00, 4'b1100);
      peek0("r1_add", 4'd1, 8'h00);
      run(0, "ldi_r3", 16'h9301, 1, 4'd3, 8'h01, 4'b1100);
      run(0, "adc",    16'h2333, 1, 4'd3, 8'h03, 4'b0000);
      // rd==rr uses pre-instruction value
      run(0, "add_dbl", 16'h1333, 1, 4'd3, 8'h06, 4'b0000);

      // SUB with borrow, AND keeps C
      run(0, "ldi_r4", 16'h9410, 1, 4'd4, 8'h10, 4'b0000);
      run(0, "ldi_r5", 16'h9520, 1, 4'd5, 8'h20, 4'b0000);
      run(0, "sub_brw", 16'h3450, 1, 4'd4, 8'hF0, 4'b1001);
      run(0, "and",     16'h4450, 1, 4'd4, 8'h20, 4'b1000);

      // SUB overflow, ANDI clears V, MOV and EOR
      run(0, "ldi_r6", 16'h9680, 1, 4'd6, 8'h80, 4'b1000);
      run(0, "ldi_r7", 16'h9701, 1, 4'd7, 8'h01, 4'b1000);
      run(0, "sub_ovf", 16'h3670, 1, 4'd6, 8'h7F, 4'b0010);
      run(0, "andi",    16'h860F, 1, 4'd6, 8'h0F, 4'b0000);
      run(0, "mov",     16'h7A60, 1, 4'd10, 8'h0F, 4'b0000);
      run(0, "eor",     16'h6AA0, 1, 4'd10, 8'h00, 4'b0100);
      run(0, "or",      16'h5540, 1, 4'd5, 8'h20, 4'b0000);
      run(0, "nop",     16'h0000, 0, 4'd0, 8'h00, 4'b0000);

      // Illegal opcode, then sticky across a legal instruction
      run(0, "ill_op", 16'hF000, 0, 4'd0, 8'h00, 4'b0000);
      check_eq("ill_set", illegal0, 1);
      run(0, "ldi_r11", 16'h9B42, 1, 4'd11, 8'h42, 4'b0000);
      check_eq("ill_sticky", illegal0, 1);
      peek0("r5_or", 4'd5, 8'h20);

      // NREG=4 instance: out-of-range rd and rr
      run(1, "n4_ldi", 16'h9133, 1, 4'd1, 8'h33, 4'b0000);
      check_eq("n4_ill0", illegal1, 0);
      run(1, "n4_rd5", 16'h9507, 0, 4'd0, 8'h00, 4'b0000);
      check_eq("n4_ill1", illegal1, 1);
      run(1, "n4_rr5", 16'h1150, 0, 4'd0, 8'h00, 4'b0000);
      run(1, "n4_ldi2", 16'h9244, 1, 4'd2, 8'h44, 4'b0000);
      check_eq("n4_sticky", illegal1, 1);
      dbg_addr1 = 4'd1; #1;
      check_eq("n4_r1", dbg_data1, 32'h33);
      dbg_addr1 = 4'd5; #1;
      check_eq("n4_dbg_oor", dbg_data1, 32'h00);

      // Backpressure: idle FETCH for 3 cycles
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("bp_ready", inst_ready0, 1);
         check_eq("bp_wbv", wb_valid0, 0);
      end
      run(0, "bp_ldi", 16'h9CC3, 1, 4'd12, 8'hC3, 4'b0000);
      peek0("r12", 4'd12, 8'hC3);

      // Reset during EXEC of LDI R1,0xFF
      inst0 = 16'h91FF; inst_valid0 = 1'b1;
      @(negedge clk);
      inst_valid0 = 1'b0;
      check_eq("rx_exec", inst_ready0, 0);
      rst = 1'b1;
      #1;
      check_eq("rx_wbv", wb_valid0, 0);
      @(negedge clk);
      rst = 1'b0;
      check_eq("rx_ready", inst_ready0, 1);
      check_eq("rx_flags", flags0, 0);
      check_eq("rx_illegal", illegal0, 0);
      peek0("rx_r1", 4'd1, 8'h00);
      peek0("rx_r12", 4'd12, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_n.md
CORE_N -- requirements
Module: core_n

Interface
REQ-001 SHALL have parameter DW, default 8, datapath width in bits; legal range 8..32.
REQ-002 SHALL have parameter NREG, default 16, number of general-purpose registers; legal range 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst  input  16  instruction word.
REQ-006 SHALL have port inst_valid  input  1  inst holds an instruction.
REQ-007 SHALL have port inst_ready  output  1  core accepts inst this cycle.
REQ-008 SHALL have port wb_valid  output  1  register writeback occurs at the next edge.
REQ-009 SHALL have port wb_addr  output  4  writeback register index.
REQ-010 SHALL have port wb_data  output  DW  writeback value.
REQ-011 SHALL have port flags  output  4  status register {C,Z,V,N}, bit 3 = C.
REQ-012 SHALL have port illegal  output  1  sticky illegal-instruction indicator.
REQ-013 SHALL have port dbg_addr  input  4  debug register select.
REQ-014 SHALL have port dbg_data  output  DW  combinational content of R[dbg_addr]; 0 if dbg_addr >= NREG.

Function
REQ-015 SHALL decode fields as op=inst[15:12], rd=[11:8], rr=[7:4], K=[7:0] zero-extended to DW.
REQ-016 SHALL implement a two-state FSM: FETCH (inst_ready=1) and EXEC (inst_ready=0).
REQ-017 SHALL, in FETCH with inst_valid=1 at the edge, capture inst into IR and go to EXEC; with inst_valid=0 it SHALL remain in FETCH with no state change.
REQ-018 SHALL, in EXEC, compute the result combinationally, update rd and flags at the next edge, and return to FETCH; throughput is one instruction per 2 cycles.
REQ-019 SHALL assert wb_valid only in EXEC, and only for writing opcodes with rd < NREG.
REQ-020 SHALL implement the opcodes: 0 NOP; 1 ADD rd+rr; 2 ADC rd+rr+C; 3 SUB rd-rr; 4 AND; 5 OR; 6 EOR; 7 MOV rd<=rr; 8 ANDI rd&K; 9 LDI rd<=K.
REQ-021 SHALL treat opcodes A-F, and any rd or rr >= NREG, as illegal: no register or flag write, illegal set to 1.
REQ-022 SHALL compute flags for ADD/ADC/SUB as: C = carry-out (borrow for SUB); V = two's-complement overflow; Z = (result==0); N = result[DW-1].
REQ-023 SHALL, for AND/OR/EOR/ANDI, set V=0, update Z and N, and leave C unchanged.
REQ-024 SHALL leave all flags unchanged for NOP, MOV, LDI and illegal instructions.
REQ-025 SHALL use the pre-instruction register values when rd==rr (e.g. ADD R3,R3 doubles R3).
REQ-026 SHALL clear illegal only on rst.

Reset
REQ-027 SHALL, while rst=1 at an edge: go to FETCH, clear IR, all registers, flags and illegal to 0; inst_ready SHALL be 1 in the first cycle after reset.
REQ-028 SHALL, with rst=1 during EXEC, suppress the pending writeback; reset takes priority over all updates.

Structure
REQ-029 SHALL place opcode constants, the FSM state enum and flag bit indices in the shared package core_n_pkg.
REQ-030 SHALL place arithmetic and flag generation in the sub-module core_n_alu (DW-parametrised, combinational); the register file and FSM remain in core_n.

Verification
REQ-031 SHALL cover LDI: DW=8, inst 0x915A accepted -> in EXEC wb_valid=1, wb_addr=1, wb_data=0x5A; flags stay 0000.
REQ-032 SHALL cover ADD carry/zero: after LDI R1,0x5A and LDI R2,0xA6 (0x92A6), ADD 0x1120 -> R1=0x00, flags=1100.
REQ-033 SHALL cover ADC: with C=1, LDI R3,0x01 then ADC 0x2333 -> R3=0x03, flags=0000.
REQ-034 SHALL cover illegal instructions: 0xF000, and with NREG=4 LDI 0x9507 -> no wb_valid, illegal=1 and sticky, registers and flags unchanged.
REQ-035 SHALL cover backpressure: inst_valid low 3 cycles in FETCH -> inst_ready stays 1, no writeback; the instruction is then accepted on the first valid cycle.
REQ-036 SHALL cover reset mid-EXEC: rst asserted during EXEC of LDI R1,0xFF -> dbg_data(R1)=0x00, state FETCH, flags=0000.
